// File: rtl/ram_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_test_pkg
// Brief    : Shared FSM state encoding, mismatch phase codes and the
//            address-derived test pattern for the BRAM test sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_READ       = 3'd2,
        ST_ERROR_WAIT = 3'd3,
        ST_LOOP_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] ERR_STATE_NORMAL = 2'b10;
    localparam logic [1:0] ERR_STATE_INV    = 2'b11;

    // Data bit i mirrors address bit (i mod addr_width), flipped on odd loops.
    function automatic logic pattern_bit(input logic [63:0]   addr,
                                         input int unsigned   addr_width,
                                         input int unsigned   bit_idx,
                                         input logic          inv);
        logic [5:0] k;
        k = 6'(bit_idx % addr_width);
        return addr[k] ^ inv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_test_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_test_sequencer_if
// Brief    : BRAM port plus control/report signals of the test sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_test_sequencer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 1
);
    logic                  enable;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  report_ack;
    logic                  error_detected;
    logic [1:0]            error_state;
    logic [ADDR_WIDTH-1:0] error_address;
    logic [DATA_WIDTH-1:0] expected_data;
    logic [DATA_WIDTH-1:0] actual_data;
    logic                  loop_complete;
    logic [15:0]           error_count;

    modport master (
        input  enable, ram_rdata, report_ack,
        output ram_addr, ram_we, ram_wdata, error_detected, error_state,
               error_address, expected_data, actual_data, loop_complete,
               error_count
    );

    modport slave (
        output enable, ram_rdata, report_ack,
        input  ram_addr, ram_we, ram_wdata, error_detected, error_state,
               error_address, expected_data, actual_data, loop_complete,
               error_count
    );
endinterface
`default_nettype wire

// File: rtl/ram_test_compare.sv
`default_nettype none
// ============================================================================
// Module   : ram_test_compare
// Brief    : One-deep compare stage aligning an issued read address and its
//            expected pattern with the synchronous BRAM read data.
// Revision : 1.0 - initial release
// ============================================================================
module ram_test_compare #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_issue,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_expected,
    input  wire logic [DATA_WIDTH-1:0] i_rdata,
    output logic                       o_valid,
    output logic      [ADDR_WIDTH-1:0] o_addr,
    output logic      [DATA_WIDTH-1:0] o_expected,
    output logic                       o_mismatch
);
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;

    always_comb begin
        valid_d = i_issue;
        addr_d  = addr_q;
        exp_d   = exp_q;
        if (i_issue) begin
            addr_d = i_addr;
            exp_d  = i_expected;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            exp_q   <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            exp_q   <= exp_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_addr     = addr_q;
    assign o_expected = exp_q;
    assign o_mismatch = valid_q && (i_rdata != exp_q);
endmodule
`default_nettype wire

// File: rtl/ram_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ram_test_sequencer
// Brief    : Write/read-back BRAM march with alternating pattern polarity,
//            held mismatch and loop-end reports released by report_ack.
// Revision : 1.0 - initial release
// ============================================================================
module ram_test_sequencer
    import ram_test_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ram_test_sequencer_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inv_q, inv_d;
    logic                  read_done_q, read_done_d;
    logic [15:0]           error_count_q, error_count_d;
    logic                  error_detected_q, error_detected_d;
    logic [1:0]            error_state_q, error_state_d;
    logic [ADDR_WIDTH-1:0] error_address_q, error_address_d;
    logic [DATA_WIDTH-1:0] expected_q, expected_d;
    logic [DATA_WIDTH-1:0] actual_q, actual_d;
    logic                  loop_complete_q, loop_complete_d;

    logic [DATA_WIDTH-1:0] w_pattern;
    logic                  w_issue;
    logic                  w_cmp_valid;
    logic [ADDR_WIDTH-1:0] w_cmp_addr;
    logic [DATA_WIDTH-1:0] w_cmp_expected;
    logic                  w_mismatch;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_pattern
            assign w_pattern[gi] = pattern_bit(64'(addr_q), ADDR_WIDTH, gi, inv_q);
        end
    endgenerate

    // A failing compare suppresses the issue of the same cycle, flushing A+1.
    assign w_issue = (state_q == ST_READ) && !read_done_q && !w_mismatch;

    ram_test_compare #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_compare (
        .clk        (clk),
        .rst        (rst),
        .i_issue    (w_issue),
        .i_addr     (addr_q),
        .i_expected (w_pattern),
        .i_rdata    (bus.ram_rdata),
        .o_valid    (w_cmp_valid),
        .o_addr     (w_cmp_addr),
        .o_expected (w_cmp_expected),
        .o_mismatch (w_mismatch)
    );

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        inv_d            = inv_q;
        read_done_d      = read_done_q;
        error_count_d    = error_count_q;
        error_detected_d = error_detected_q;
        error_state_d    = error_state_q;
        error_address_d  = error_address_q;
        expected_d       = expected_q;
        actual_d         = actual_q;
        loop_complete_d  = loop_complete_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_WRITE;
                    addr_d  = '0;
                end
            end
            ST_WRITE: begin
                if (addr_q == c_LAST_ADDR) begin
                    state_d     = ST_READ;
                    addr_d      = '0;
                    read_done_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_READ: begin
                if (w_mismatch) begin
                    state_d          = ST_ERROR_WAIT;
                    error_detected_d = 1'b1;
                    error_state_d    = inv_q ? ERR_STATE_INV : ERR_STATE_NORMAL;
                    error_address_d  = w_cmp_addr;
                    expected_d       = w_cmp_expected;
                    actual_d         = bus.ram_rdata;
                    if (error_count_q != 16'hFFFF) begin
                        error_count_d = error_count_q + 16'd1;
                    end
                end else begin
                    if (w_cmp_valid && (w_cmp_addr == c_LAST_ADDR)) begin
                        state_d         = ST_LOOP_DONE;
                        loop_complete_d = 1'b1;
                    end
                    if (w_issue) begin
                        if (addr_q == c_LAST_ADDR) begin
                            read_done_d = 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
            end
            ST_ERROR_WAIT: begin
                if (bus.report_ack) begin
                    error_detected_d = 1'b0;
                    if (error_address_q == c_LAST_ADDR) begin
                        state_d         = ST_LOOP_DONE;
                        loop_complete_d = 1'b1;
                    end else begin
                        state_d     = ST_READ;
                        addr_d      = error_address_q + 1'b1;
                        read_done_d = 1'b0;
                    end
                end
            end
            ST_LOOP_DONE: begin
                if (bus.report_ack) begin
                    loop_complete_d = 1'b0;
                    inv_d           = ~inv_q;
                    if (bus.enable) begin
                        state_d = ST_WRITE;
                        addr_d  = '0;
                    end else begin
                        state_d         = ST_IDLE;
                        addr_d          = '0;
                        error_state_d   = '0;
                        error_address_d = '0;
                        expected_d      = '0;
                        actual_d        = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            inv_q            <= 1'b0;
            read_done_q      <= 1'b0;
            error_count_q    <= '0;
            error_detected_q <= 1'b0;
            error_state_q    <= '0;
            error_address_q  <= '0;
            expected_q       <= '0;
            actual_q         <= '0;
            loop_complete_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            inv_q            <= inv_d;
            read_done_q      <= read_done_d;
            error_count_q    <= error_count_d;
            error_detected_q <= error_detected_d;
            error_state_q    <= error_state_d;
            error_address_q  <= error_address_d;
            expected_q       <= expected_d;
            actual_q         <= actual_d;
            loop_complete_q  <= loop_complete_d;
        end
    end

    assign bus.ram_we         = (state_q == ST_WRITE);
    assign bus.ram_addr       = ((state_q == ST_WRITE) || (state_q == ST_READ)) ? addr_q : '0;
    assign bus.ram_wdata      = (state_q == ST_WRITE) ? w_pattern : '0;
    assign bus.error_detected = error_detected_q;
    assign bus.error_state    = error_state_q;
    assign bus.error_address  = error_address_q;
    assign bus.expected_data  = expected_q;
    assign bus.actual_data    = actual_q;
    assign bus.loop_complete  = loop_complete_q;
    assign bus.error_count    = error_count_q;
endmodule
`default_nettype wire

// File: doc/ram_test_sequencer.md
RAM_TEST_SEQUENCER -- requirements
Module: ram_test_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, BRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 1, BRAM data width.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk, rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 enable  input  1  start/continue test loops; sampled only in IDLE and LOOP_DONE.
REQ-007 ram_addr  output  ADDR_WIDTH  BRAM address.
REQ-008 ram_we  output  1  BRAM write enable.
REQ-009 ram_wdata  output  DATA_WIDTH  BRAM write data.
REQ-010 ram_rdata  input  DATA_WIDTH  BRAM read data, valid 1 cycle after address (synchronous read).
REQ-011 report_ack  input  1  single-cycle pulse from the error output logic; acknowledges the held report.
REQ-012 error_detected  output  1  mismatch report held.
REQ-013 error_state  output  2  phase of the mismatch: 2'b10 normal pattern, 2'b11 inverted pattern.
REQ-014 error_address, expected_data, actual_data  output  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH  mismatch details.
REQ-015 loop_complete  output  1  loop-end report held.
REQ-016 error_count  output  16  saturating mismatch count since reset.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ, ERROR_WAIT, LOOP_DONE.
REQ-018 Pattern SHALL be bit i = addr[i mod ADDR_WIDTH] XOR inv, where inv is a loop-parity flag (0 on the first loop, toggled at each LOOP_DONE exit).
REQ-019 IDLE: all outputs 0; go to WRITE with address 0 when enable=1.
REQ-020 WRITE: ram_we=1, ram_addr increments by 1 each cycle from 0 to 2^ADDR_WIDTH-1, ram_wdata=pattern(addr); after the last address go to READ with address 0.
REQ-021 READ: ram_we=0, issue one address per cycle; a compare stage registers the issued address and expected pattern and compares it with ram_rdata one cycle later.
REQ-022 On mismatch at address A: error_detected=1 and error_state/error_address/expected_data/actual_data latched the same cycle the compare fails (registered next edge); the FSM goes to ERROR_WAIT; the in-flight read of A+1 is discarded.
REQ-023 ERROR_WAIT: outputs held stable, no RAM access; on report_ack, clear error_detected and resume READ issuing at A+1, or go to LOOP_DONE if A is the last address.
REQ-024 Once the compare of the last address passes, the FSM SHALL go to LOOP_DONE.
REQ-025 LOOP_DONE: loop_complete=1 held until report_ack; then clear it, toggle inv, and go to WRITE if enable=1, else IDLE.
REQ-026 report_ack outside ERROR_WAIT/LOOP_DONE SHALL be ignored.
REQ-027 If report_ack arrives in the cycle a report first asserts, the report SHALL still be visible for at least one cycle.
REQ-028 error_count SHALL increment once per mismatch and saturate at 16'hFFFF.
REQ-029 Address counters SHALL be ADDR_WIDTH wide; wrap-around is never used as loop termination; use a last-address compare.

Reset
REQ-030 rst SHALL return the FSM to IDLE in one cycle from any state, including mid-pass and ERROR_WAIT.
REQ-031 On rst, all outputs, inv, error_count and the compare stage SHALL be cleared to 0.

Structure
REQ-032 The FSM state enum and the error_state encodings SHALL live in a shared package ram_test_pkg.
REQ-033 The pattern function SHALL live in ram_test_pkg.
REQ-034 The compare stage SHALL be one sub-module, ram_test_compare.
REQ-035 No other sub-modules are required.

Verification (ADDR_WIDTH=4, DATA_WIDTH=1, ideal BRAM model)
REQ-036 Clean loop: enable=1 for 16 write cycles, then 16 reads. Required response: loop_complete=1 with no error; after ack the second WRITE uses the inverted pattern (ram_wdata at addr 0 = 1).
REQ-037 Injected fault: force rdata at addr 5 wrong in loop 0. Required response: error_detected=1 with error_address=5, error_state=2'b10, expected=1, actual=0; after ack, reads resume at 6 and error_count=1.
REQ-038 Fault at last address 15 in loop 1. Required response: error_state=2'b11; after ack, go straight to LOOP_DONE.
REQ-039 Delayed ack: hold report_ack low for 100 cycles in ERROR_WAIT. Required response: no RAM access, outputs unchanged.
REQ-040 Reset mid-READ and in ERROR_WAIT. Required response: next cycle in IDLE with all outputs 0; the restart writes the non-inverted pattern.
REQ-041 enable=0 at LOOP_DONE ack. Required response: FSM in IDLE; a stray report_ack there has no effect.
